// File: rtl/puzzle_pkg.sv
// puzzle_pkg: shared definitions for the slide-puzzle datapath.
// Holds decoder direction codes, board geometry, the solved board constant,
// the controller FSM states and the target-cell/legality helper used by both
// the shuffle and play paths of puzzle_board_ctrl.
package puzzle_pkg;

   localparam int CELL_W  = 4;
   localparam int N_CELLS = 9;

   localparam logic [2:0] DIR_NONE  = 3'd0;
   localparam logic [2:0] DIR_UP    = 3'd1;
   localparam logic [2:0] DIR_DOWN  = 3'd2;
   localparam logic [2:0] DIR_LEFT  = 3'd3;
   localparam logic [2:0] DIR_RIGHT = 3'd4;

   // Cells 0-7 hold tiles 1-8, cell 8 holds the blank (tile 0).
   localparam logic [N_CELLS*CELL_W-1:0] SOLVED_BOARD = 36'h087654321;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHUFFLE,
      S_PLAY,
      S_CHECK,
      S_WON
   } state_e;

   // Returns {legal, target_cell}. The tile moves in the arrow direction into
   // the blank, so the blank itself moves the opposite way.
   function automatic logic [4:0] cell_target(input logic [3:0] blank,
                                              input logic [2:0] dir);
      logic       legal;
      logic [3:0] tgt;
      legal = 1'b0;
      tgt   = blank;
      case (dir)
         DIR_UP:    if (blank < 4'd6)  begin legal = 1'b1; tgt = blank + 4'd3; end
         DIR_DOWN:  if (blank >= 4'd3) begin legal = 1'b1; tgt = blank - 4'd3; end
         DIR_LEFT:  if (blank != 4'd2 && blank != 4'd5 && blank != 4'd8) begin
                       legal = 1'b1; tgt = blank + 4'd1;
                    end
         DIR_RIGHT: if (blank != 4'd0 && blank != 4'd3 && blank != 4'd6) begin
                       legal = 1'b1; tgt = blank - 4'd1;
                    end
         default:   ;
      endcase
      return {legal, tgt};
   endfunction

endpackage

// File: rtl/puzzle_board_ctrl_if.sv
// puzzle_board_ctrl_if: key-event inputs and board outputs of the puzzle
// controller.
//   direction/move/start : from the keyboard decoder (master drives)
//   board/blank_pos/move_count/board_changed/busy/solved : to the renderer
interface puzzle_board_ctrl_if;
   import puzzle_pkg::*;

   logic [2:0]                  direction;
   logic                        move;
   logic                        start;
   logic [N_CELLS*CELL_W-1:0]   board;
   logic [3:0]                  blank_pos;
   logic [15:0]                 move_count;
   logic                        board_changed;
   logic                        busy;
   logic                        solved;

   modport master (output direction, move, start,
                   input  board, blank_pos, move_count, board_changed, busy, solved);
   modport slave  (input  direction, move, start,
                   output board, blank_pos, move_count, board_changed, busy, solved);
endinterface

// File: rtl/puzzle_lfsr16.sv
// puzzle_lfsr16: free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
//   CLOCK_50 : clock
//   resetn   : async active-low reset, loads SEED (must be nonzero)
//   lfsr_o   : current 16-bit state
module puzzle_lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   output logic [15:0] lfsr_o
);
   logic [15:0] lfsr_q;
   logic        fb;

   // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
   assign fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) lfsr_q <= SEED;
      else         lfsr_q <= {fb, lfsr_q[15:1]};
   end

   assign lfsr_o = lfsr_q;
endmodule

// File: rtl/puzzle_board_ctrl.sv
// puzzle_board_ctrl: 3x3 slide-puzzle game logic.
//   CLOCK_50 : clock;  resetn : async active-low reset
//   bus      : slave side of puzzle_board_ctrl_if (key levels in, board out)
// Start rising edge shuffles with SHUFFLE_STEPS random legal-or-dropped
// moves; each move falling edge in play applies one legal slide; a win is
// flagged one cycle after the solving move.
module puzzle_board_ctrl
   import puzzle_pkg::*;
#(
   parameter int          SHUFFLE_STEPS = 64,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   puzzle_board_ctrl_if.slave  bus
);
   localparam int CNT_W = (SHUFFLE_STEPS > 1) ? $clog2(SHUFFLE_STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SHUFFLE_STEPS - 1);

   state_e                             state_q, state_d;
   logic [N_CELLS-1:0][CELL_W-1:0]     board_q, board_d;
   logic [3:0]                         blank_q, blank_d;
   logic [15:0]                        mc_q, mc_d;
   logic [CNT_W-1:0]                   step_q, step_d;
   logic                               chg_q, chg_d;
   logic                               move_q, start_q;

   logic [15:0] lfsr;
   logic        start_ev, move_ev;
   logic        swap_en;
   logic [3:0]  swap_tgt;
   logic [4:0]  shuf_t, play_t;

   puzzle_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .lfsr_o   (lfsr)
   );

   // Decoder holds the arrow code through key release, so act on the
   // falling edge of move.
   assign start_ev = bus.start & ~start_q;
   assign move_ev  = move_q & ~bus.move;

   // lfsr[1:0] = 00..11 maps onto codes up..right.
   assign shuf_t = cell_target(blank_q, {1'b0, lfsr[1:0]} + 3'd1);
   assign play_t = cell_target(blank_q, bus.direction);

   always_comb begin
      state_d  = state_q;
      board_d  = board_q;
      blank_d  = blank_q;
      mc_d     = mc_q;
      step_d   = step_q;
      swap_en  = 1'b0;
      swap_tgt = blank_q;

      if (start_ev) begin
         // Start wins over everything, including a shuffle in progress.
         state_d = S_SHUFFLE;
         step_d  = '0;
      end else begin
         case (state_q)
            S_SHUFFLE: begin
               if (SHUFFLE_STEPS == 0) begin
                  state_d = S_PLAY;
                  mc_d    = '0;
               end else begin
                  swap_en  = shuf_t[4];
                  swap_tgt = shuf_t[3:0];
                  if (step_q == LAST_STEP) begin
                     state_d = S_PLAY;
                     mc_d    = '0;
                  end else begin
                     step_d = step_q + CNT_W'(1);
                  end
               end
            end
            S_PLAY: begin
               if (move_ev && play_t[4]) begin
                  swap_en  = 1'b1;
                  swap_tgt = play_t[3:0];
                  if (mc_q != 16'hFFFF) mc_d = mc_q + 16'd1;
                  state_d  = S_CHECK;
               end
            end
            S_CHECK: state_d = (board_q == SOLVED_BOARD) ? S_WON : S_PLAY;
            default: ;  // S_IDLE / S_WON: board frozen until start
         endcase
      end

      if (swap_en) begin
         board_d[blank_q]  = board_q[swap_tgt];
         board_d[swap_tgt] = '0;
         blank_d           = swap_tgt;
      end
      chg_d = swap_en;
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         board_q <= SOLVED_BOARD;
         blank_q <= 4'd8;
         mc_q    <= '0;
         step_q  <= '0;
         chg_q   <= 1'b0;
         move_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         board_q <= board_d;
         blank_q <= blank_d;
         mc_q    <= mc_d;
         step_q  <= step_d;
         chg_q   <= chg_d;
         move_q  <= bus.move;
         start_q <= bus.start;
      end
   end

   assign bus.board         = board_q;
   assign bus.blank_pos     = blank_q;
   assign bus.move_count    = mc_q;
   assign bus.board_changed = chg_q;
   assign bus.busy          = (state_q == S_SHUFFLE);
   assign bus.solved        = (state_q == S_WON);
endmodule

// File: doc/puzzle_board_ctrl.md
# puzzle_board_ctrl

Game-logic stage directly downstream of the keyboard decoder. It consumes the decoder's `direction`/`move`/`start` levels and owns the 3x3 slide-puzzle board state. It shuffles the board with legal random moves on start, applies one legal tile slide per arrow keypress, counts moves and flags a win. Its board outputs feed the VGA renderer.

## Interface
- `SHUFFLE_STEPS`, default 64: number of random shuffle step slots per start; 0 is legal and means no shuffle.
- `LFSR_SEED`, default 16'hACE1: LFSR value loaded at reset; must be nonzero.
- `CLOCK_50`  in  1  system clock; single clock domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `direction`  in  3  decoder code: 000 none, 001 up, 010 down, 011 left, 100 right; 101–111 ignored.
- `move`  in  1  level, high while an extended key is held.
- `start`  in  1  level; its rising edge requests a new game.
- `board`  out  36  cell i at `board[4i+3:4i]`, row-major, cell 0 top-left; tile 0 is the blank.
- `blank_pos`  out  4  cell index (0–8) of the blank.
- `move_count`  out  16  player moves since the last shuffle ended; saturates at 16'hFFFF.
- `board_changed`  out  1  one-cycle pulse after any swap, player or shuffle.
- `busy`  out  1  high in S_SHUFFLE.
- `solved`  out  1  high in S_WON.

## Operation
- Edge detect: `move_d` and `start_d` are registered copies. A move event is `move_d & ~move`, the falling edge, because the decoder's `direction` holds the arrow code at key release. A start event is `start & ~start_d`.
- Arrow semantics (the tile moves in the arrow direction into the blank):
  - up: blank += 3; illegal if the blank is in row 2.
  - down: blank -= 3; illegal if the blank is in row 0.
  - left: blank += 1; illegal if the blank is in column 2.
  - right: blank -= 1; illegal if the blank is in column 0.
- A swap exchanges the blank cell with the target cell and updates `blank_pos`.
- FSM states:
  - S_IDLE: the solved board is shown and move events are ignored. Start event -> S_SHUFFLE.
  - S_SHUFFLE:
    - Clear the step counter on entry.
    - Each cycle consumes one step slot. `lfsr[1:0]` picks the direction: 00 up, 01 down, 10 left, 11 right.
    - An illegal pick consumes the slot without a swap.
    - After `SHUFFLE_STEPS` slots: `move_count`=0 -> S_PLAY. A shuffled board that happens to be solved is not flagged.
  - S_PLAY:
    - Legal move event: swap, `move_count`+1 (saturating) -> S_CHECK.
    - Illegal direction or code none/101–111: no swap, no count, no pulse; stay in S_PLAY.
  - S_CHECK: one cycle. Compare `board` to SOLVED_BOARD: equal -> S_WON, otherwise -> S_PLAY. Move events in this cycle are dropped.
  - S_WON: board frozen and move events ignored. Start event -> S_SHUFFLE.
- A start event in any state, including S_SHUFFLE (which restarts the step counter) and S_CHECK, goes to S_SHUFFLE. Start has priority over a simultaneous move event.
- The LFSR is a Fibonacci x^16+x^14+x^13+x^11+1 and advances every cycle from reset. Shuffles therefore depend on start timing.

## Timing
- Reset values (asynchronous):
  - state S_IDLE;
  - `board` = SOLVED_BOARD, i.e. cells 0–7 hold tiles 1–8 and cell 8 holds 0;
  - `blank_pos`=8, `move_count`=0;
  - `board_changed`=0, `busy`=0, `solved`=0;
  - `move_d`=`start_d`=0;
  - lfsr=`LFSR_SEED`.
- Move latency: a falling edge is detected in cycle T. `board`, `blank_pos` and `move_count` update at the end of T. `board_changed` is high during T+1, S_CHECK is T+1, and `solved` can first be high in T+2.
- Start latency: the edge is detected in cycle T and S_SHUFFLE begins in T+1. `busy` is high for exactly `SHUFFLE_STEPS` cycles, or 1 cycle when the parameter is 0. S_PLAY follows.
- During shuffle, `board_changed` pulses once per cycle after each legal step.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `puzzle_pkg`, shared with keyboard_decoder and the renderer, holds:
  - direction codes DIR_NONE/UP/DOWN/LEFT/RIGHT;
  - CELL_W=4 and N_CELLS=9;
  - the SOLVED_BOARD constant;
  - the FSM state enum.
- One sub-module `puzzle_lfsr16` (`CLOCK_50`, `resetn`, seed parameter, 16-bit state out).
- Target-cell calculation and legality check are a shared combinational function, used by both the shuffle and play paths.

## Test plan
- Reset held, then released -> `board`=36'h087654321, `blank_pos`=8, `move_count`=0, and `solved`/`busy`/`board_changed`=0.
- `SHUFFLE_STEPS`=0, then a start pulse -> `busy` high 1 cycle, then S_PLAY with the board unchanged.
- Then move with `direction`=010 (down) -> cell 8=6, cell 5=0, `blank_pos`=5, `move_count`=1, one `board_changed` pulse, `solved`=0.
- Then move with `direction`=001 (up) -> `blank_pos`=8, `move_count`=2, `solved`=1 two cycles after the edge. Further moves are ignored in S_WON.
- With `blank_pos`=8, move with 011 (left), 001 (up) or 111 -> no board change, no count, no pulse.
- Default parameters: start pulse -> `busy` high exactly 64 cycles. The final board must match a cycle-accurate model driven by the same LFSR. Every `board_changed` must be a single legal adjacent swap, and a start pulse during the shuffle must restart it for 64 cycles.
